// File: rtl/sonic_vc_timing_adapter_rl_source.sv
// Ready-latency-0 to ready-latency-N Avalon-ST egress adapter with registered outputs and beat statistics.
// Optional upstream stall counter is built only when SONIC_VC_TA_STALL_CNT_EN is defined.
module sonic_vc_timing_adapter_rl_source #(
  parameter int DATA_WIDTH    = 133,
  parameter int READY_LATENCY = 2,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  clear_stats,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  stall_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic grant;
  logic take;

  if (READY_LATENCY < 1 || READY_LATENCY > 4) begin : g_bad_latency
    $error("sonic_vc_timing_adapter_rl_source: READY_LATENCY must be in 1..4");
  end

  // The grant seen now is the sink's ready from READY_LATENCY-1 cycles ago;
  // one more cycle is spent in the output register, giving the full latency.
  if (READY_LATENCY == 1) begin : g_rl1
    assign grant = out_ready;
  end else begin : g_rl_pipe
    logic [READY_LATENCY-2:0] rdy_pipe;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rdy_pipe <= '0;
      end else begin
        rdy_pipe[0] <= out_ready;
        for (int k = 1; k < READY_LATENCY - 1; k++) begin
          rdy_pipe[k] <= rdy_pipe[k-1];
        end
      end
    end

    assign grant = rdy_pipe[READY_LATENCY-2];
  end

  assign in_ready = grant;
  assign take     = in_valid & grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= take;
      if (take) begin
        out_data <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_count <= '0;
    end else if (clear_stats) begin
      beat_count <= '0;
    end else if (out_valid) begin
      beat_count <= beat_count + CNT_ONE;
    end
  end

`ifdef SONIC_VC_TA_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (clear_stats) begin
      stall_count <= '0;
    end else if (in_valid && !grant) begin
      stall_count <= stall_count + CNT_ONE;
    end
  end
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_sonic_vc_timing_adapter_rl_source.sv
// Scoreboard bench for sonic_vc_timing_adapter_rl_source: four instances, READY_LATENCY 1..4,
// driven side by side, each checked against an independent grant/beat model.
module tb_sonic_vc_timing_adapter_rl_source;
  localparam int DW = 133;
  localparam int CW = 32;
  localparam int N  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          clr;
  logic          iv   [N];
  logic [DW-1:0] id   [N];
  logic          ir   [N];
  logic          ordy [N];
  logic          ov   [N];
  logic [DW-1:0] od   [N];
  logic [CW-1:0] bcnt [N];
  logic [CW-1:0] scnt [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    sonic_vc_timing_adapter_rl_source #(
      .DATA_WIDTH(DW), .READY_LATENCY(g + 1), .CNT_WIDTH(CW)
    ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(iv[g]), .in_data(id[g]), .in_ready(ir[g]),
      .out_ready(ordy[g]), .out_valid(ov[g]), .out_data(od[g]),
      .clear_stats(clr), .beat_count(bcnt[g]), .stall_count(scnt[g])
    );
  end

  typedef struct {
    int            inst;
    logic [DW-1:0] data;
  } sb_t;
  sb_t sbq[$];

  // Bench model: oh[i][k] is the out_ready driven k cycles ago (since reset release).
  logic [7:0]    oh   [N];
  logic          gm   [N];
  logic          xfer [N];
  logic [DW-1:0] xd   [N];
  logic          ev   [N];
  logic [DW-1:0] ed   [N];
  logic [CW-1:0] bc   [N];
  logic [CW-1:0] sc   [N];
  int            src  [N];
  int            total;
  int            bad;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    sbq.delete();
    for (int i = 0; i < N; i++) begin
      oh[i] = '0; gm[i] = 1'b0; xfer[i] = 1'b0; xd[i] = '0;
      ev[i] = 1'b0; ed[i] = '0; bc[i] = '0; sc[i] = '0;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("out_valid%0d", i), DW'(ov[i]), DW'(ev[i]));
      chk($sformatf("out_data%0d", i), od[i], ed[i]);
      chk($sformatf("beat_count%0d", i), DW'(bcnt[i]), DW'(bc[i]));
`ifdef SONIC_VC_TA_STALL_CNT_EN
      chk($sformatf("stall_count%0d", i), DW'(scnt[i]), DW'(sc[i]));
`else
      chk($sformatf("stall_zero%0d", i), DW'(scnt[i]), '0);
`endif
    end
  endtask

  // Advance one clock edge, update the model for that edge, then check registered outputs.
  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (reset_n) begin
        bc[i] = clr ? '0 : bc[i] + CW'(ev[i]);
        sc[i] = clr ? '0 : sc[i] + CW'(iv[i] & ~gm[i]);
        ev[i] = xfer[i];
        if (xfer[i]) ed[i] = xd[i];
        oh[i] = oh[i] << 1;
      end else begin
        oh[i] = '0;
      end
    end
    #1;
    check_outputs();
    for (int i = 0; i < N; i++) begin
      if (ov[i] === 1'b1) begin
        int k;
        k = -1;
        chk($sformatf("grant_inv%0d", i), DW'(oh[i][i+1]), DW'(1));
        for (int j = 0; j < sbq.size(); j++) begin
          if (sbq[j].inst == i && k < 0) k = j;
        end
        if (k < 0) begin
          chk($sformatf("sb_empty%0d", i), DW'(1), DW'(0));
        end else begin
          chk($sformatf("sb_data%0d", i), od[i], sbq[k].data);
          sbq.delete(k);
        end
      end
    end
  endtask

  // After inputs are driven: check in_ready and record upstream transfers.
  task automatic settle();
    #1;
    for (int i = 0; i < N; i++) begin
      oh[i][0] = ordy[i];
      gm[i]    = oh[i][i];
      chk($sformatf("in_ready%0d", i), DW'(ir[i]), DW'(gm[i]));
      xfer[i] = reset_n & iv[i] & gm[i];
      if (xfer[i]) begin
        xd[i] = id[i];
        sbq.push_back('{inst: i, data: id[i]});
        src[i]++;
      end
    end
  endtask

  task automatic set_in(input int i, input logic v, input logic r);
    logic [159:0] rnd;
    rnd     = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    iv[i]   = v;
    ordy[i] = r;
    id[i]   = v ? {5'(i), 96'h0, 32'(src[i])} : rnd[DW-1:0];
  endtask

  task automatic step(input logic v, input logic r, input logic c);
    cycle();
    for (int i = 0; i < N; i++) set_in(i, v, r);
    clr = c;
    settle();
  endtask

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b1; clr = 1'b0;
    for (int i = 0; i < N; i++) begin
      iv[i] = 1'b0; id[i] = '0; ordy[i] = 1'b0; src[i] = 0;
    end
    model_clear();
    #2 reset_n = 1'b0;
    #1 check_outputs();
    settle();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);

    // Release with out_ready low in the release cycle, then continuous flow.
    cycle();
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) set_in(i, 1'b1, 1'b0);
    settle();
    for (int c = 0; c < 14; c++) step(1'b1, 1'b1, 1'b0);

    // out_ready dropped for a 4-cycle run.
    for (int c = 0; c < 20; c++) step(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++)  step(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 12; c++) step(1'b1, 1'b1, 1'b0);

    // out_ready toggling every cycle, with one clear_stats in the middle.
    for (int c = 0; c < 12; c++) step(1'b1, logic'(c % 2), logic'(c == 6));
    step(1'b1, 1'b1, 1'b0);

    // Random traffic, independent per instance.
    for (int c = 0; c < 200; c++) begin
      cycle();
      for (int i = 0; i < N; i++) set_in(i, logic'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      clr = 1'b0;
      settle();
    end

    // Sustained stall, then clear_stats during a stall cycle.
    for (int c = 0; c < 10; c++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) step(1'b0, 1'b1, 1'b0);

    // Reset asserted mid-stream while beats are being delivered.
    for (int c = 0; c < 8; c++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) chk($sformatf("pre_reset_valid%0d", i), DW'(ov[i]), DW'(1));
    #2 reset_n = 1'b0;
    model_clear();
    #1 check_outputs();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    cycle();
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) set_in(i, 1'b1, 1'b1);
    settle();
    for (int c = 0; c < 10; c++) step(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++)  step(1'b0, 1'b1, 1'b0);
    cycle();
    chk("sb_leftover", DW'(sbq.size()), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sonic_vc_timing_adapter_rl_source.md
Name: sonic_vc_timing_adapter_rl_source

Overview:
- Egress-side counterpart of the VC timing-adapter FIFO.
- Takes a ready-latency-0 Avalon-ST stream (valid/ready/data, 133-bit beats) from VC logic and drives a downstream sink that declares ready latency READY_LATENCY.
- Guarantees a beat is presented only in a cycle the sink granted READY_LATENCY cycles earlier.
- Registers data/valid outputs for timing closure and keeps beat statistics.

Parameters:
DATA_WIDTH, 133, beat width (data plus sideband, passed opaquely)
READY_LATENCY, 2, downstream sink ready latency; legal 1..4, anything else is an elaboration error
CNT_WIDTH, 32, width of statistics counters

Ports:
clk  input  1  single clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream beat valid (ready latency 0)
in_data  input  DATA_WIDTH  upstream beat
in_ready  output  1  upstream ready (ready latency 0)
out_ready  input  1  downstream ready; grants a transfer slot READY_LATENCY cycles later
out_valid  output  1  downstream beat valid, registered
out_data  output  DATA_WIDTH  downstream beat, registered
clear_stats  input  1  synchronous clear of statistics counters
beat_count  output  CNT_WIDTH  beats delivered downstream, wrapping
stall_count  output  CNT_WIDTH  upstream stall cycles (see Optional Feature)

Behaviour:
- Clock/reset: one clock, clk. reset_n is asynchronous, active-low; every register clears on negedge reset_n.
- Reset values:
  - out_valid=0, out_data=0, beat_count=0, stall_count=0.
  - Ready pipeline rdy_pipe (READY_LATENCY-1 bits) = all 0.
- Grant signal g:
  - READY_LATENCY=1: g = out_ready, combinational.
  - READY_LATENCY>=2: g = out_ready delayed by READY_LATENCY-1 registers (rdy_pipe tail).
- in_ready = g, combinational.
  - After reset deassertion with READY_LATENCY>=2, in_ready stays 0 for exactly READY_LATENCY-1 cycles even if out_ready=1.
- Upstream transfer: in_valid & in_ready in the same cycle.
- Each posedge:
  - out_valid <= in_valid & g.
  - out_data <= in_data when in_valid & g, otherwise holds its previous value.
- Latency: one cycle from upstream transfer to out_valid.
- Invariant: out_valid=1 in cycle t implies out_ready=1 in cycle t-READY_LATENCY. The bench checks this continuously.
- No buffering. A beat is never dropped or duplicated. Upstream beats not granted simply stall at the source.
- out_ready low for a run of cycles: in_ready goes low exactly READY_LATENCY-1 cycles later, for the same run length.
- out_valid may be high while the current out_ready is low; this is legal for a ready-latency sink.
- beat_count:
  - +1 in every cycle with out_valid=1; wraps at 2^CNT_WIDTH.
  - clear_stats=1 forces 0 next cycle and has priority over a simultaneous increment.
- Reset mid-stream: the in-flight beat in out_data/out_valid is discarded and rdy_pipe is flushed. Grants issued before reset are not honoured.

Optional Feature:
- Macro: SONIC_VC_TA_STALL_CNT_EN.
- Defined:
  - stall_count increments in every cycle with in_valid=1 and in_ready=0; wraps.
  - clear_stats clears it with priority, same as beat_count.
- Undefined: stall_count is tied to constant 0 and no counter logic is built. Port list is unchanged.

Test Plan:
- Reset, READY_LATENCY=2, out_ready=1 from the cycle after reset release, in_valid=1, in_data incrementing from 0 -> in_ready=0 for 1 cycle, then 1; out_valid=1 from the following cycle; out_data sequence 0,1,2,... with no gaps; beat_count=10 after 10 beats.
- READY_LATENCY=3, continuous in_valid, out_ready pulsed low for 4 cycles at cycle 20 -> in_ready low during cycles 22..25; out_valid low during cycles 23..26; data sequence unbroken; invariant holds.
- READY_LATENCY=1, out_ready toggling every cycle, in_valid=1 -> in_ready tracks out_ready combinationally; out_valid alternates 1/0; out_data holds its value through the 0 cycles.
- Random in_valid/out_ready for 200 cycles at READY_LATENCY=1..4 -> scoreboard shows no loss or duplication; out_valid never asserted without a grant READY_LATENCY cycles earlier; beat_count equals scoreboard count.
- Macro defined, in_valid=1, out_ready=0 held 5 cycles after the pipeline has settled -> stall_count=5; then clear_stats=1 in a stall cycle -> stall_count=0 next cycle. Macro undefined -> stall_count stays 0.
- Assert reset_n low mid-stream with out_valid=1 -> out_valid=0 and out_data=0 immediately; after release, in_ready obeys the initial READY_LATENCY-1 cycle blackout; first delivered beat is the next upstream beat.
